mesh_pkt_injector: RTL and testbench

- Injection side of the node-to-router local port in the cd_mesh.
- Accepts (destination, payload) commands from the processing element and encodes the 64-bit packet header: VC[63], Dx[62], Dy[61], Rsv[60:56], Hx[55:52], Hy[51:48], SrcX[47:40], SrcY[39:32], payload [31:0].
- Buffers encoded packets in a small FIFO and presents them to the router's local input port with valid/ready.
- Assigns alternating virtual channels and rejects destinations outside the mesh.

---
 rtl/mesh_pkt_injector.sv | 114 +++++++++++
 tb/tb_mesh_pkt_injector.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mesh_pkt_injector.sv
// Local-port packet injector: encodes (dst, payload) commands into mesh packets and queues them.
// One cycle from command accept to out_valid; cmd_ready drops only when the queue is full.
module mesh_pkt_injector #(
   parameter int MY_X   = 0,
   parameter int MY_Y   = 0,
   parameter int MESH_X = 4,
   parameter int MESH_Y = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [7:0]                 cmd_dst_x,
   input  logic [7:0]                 cmd_dst_y,
   input  logic [31:0]                cmd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [63:0]                out_pkt,
   output logic                       err_pulse,
   output logic [15:0]                sent_cnt,
   output logic [15:0]                drop_cnt,
   output logic [$clog2(DEPTH):0]     fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [7:0] MYX8   = MY_X[7:0];
   localparam logic [7:0] MYY8   = MY_Y[7:0];
   localparam logic [8:0] MESHX9 = MESH_X[8:0];
   localparam logic [8:0] MESHY9 = MESH_Y[8:0];
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic        vc;
      logic        dx;
      logic        dy;
      logic [4:0]  rsv;
      logic [3:0]  hx;
      logic [3:0]  hy;
      logic [7:0]  srcx;
      logic [7:0]  srcy;
      logic [31:0] data;
   } pkt_t;

   pkt_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          vc_toggle;
   logic          accept, legal, push, pop;
   logic [7:0]    dist_x, dist_y;
   pkt_t          enc;

   assign cmd_ready = (fifo_count < FULL) & ~reset;
   assign accept    = cmd_valid & cmd_ready;
   assign legal     = ({1'b0, cmd_dst_x} < MESHX9) && ({1'b0, cmd_dst_y} < MESHY9);
   assign push      = accept & legal;
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid & out_ready;

   assign dist_x = (cmd_dst_x >= MYX8) ? (cmd_dst_x - MYX8) : (MYX8 - cmd_dst_x);
   assign dist_y = (cmd_dst_y >= MYY8) ? (cmd_dst_y - MYY8) : (MYY8 - cmd_dst_y);

   always_comb begin
      enc      = '0;
      enc.vc   = vc_toggle;
      enc.dx   = (cmd_dst_x < MYX8);
      enc.dy   = (cmd_dst_y < MYY8);
      enc.hx   = dist_x[3:0];
      enc.hy   = dist_y[3:0];
      enc.srcx = MYX8;
      enc.srcy = MYY8;
      enc.data = cmd_data;
   end

   // Gate the head so stale storage is never visible while empty.
   assign out_pkt = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= enc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         vc_toggle  <= 1'b0;
         err_pulse  <= 1'b0;
         sent_cnt   <= '0;
         drop_cnt   <= '0;
      end else begin
         err_pulse <= accept & ~legal;
         if (accept & ~legal) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
         if (push) begin
            wr_ptr    <= wr_ptr + 1'b1;
            vc_toggle <= ~vc_toggle;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            sent_cnt <= sent_cnt + 16'd1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_mesh_pkt_injector.sv
// Directed bench for mesh_pkt_injector at node (1,2) of a 4x4 mesh with a 4-deep queue.
module tb_mesh_pkt_injector;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_dst_x, cmd_dst_y;
   logic [31:0] cmd_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pkt;
   logic        err_pulse;
   logic [15:0] sent_cnt, drop_cnt;
   logic [2:0]  fifo_count;

   int n_cmp = 0;
   int n_bad = 0;
   int accepts;

   mesh_pkt_injector #(.MY_X(1), .MY_Y(2), .MESH_X(4), .MESH_Y(4), .DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y), .cmd_data(cmd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
      .err_pulse(err_pulse), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic cmd(input logic [7:0] x, input logic [7:0] y, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_dst_x = x;
      cmd_dst_y = y;
      cmd_data  = d;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; out_ready = 1'b0;
      cmd_dst_x = '0; cmd_dst_y = '0; cmd_data = '0;
      tick();
      chk("rdy_in_reset", 64'(cmd_ready), 64'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pkt", out_pkt, 64'd0);
      chk("rst_fifo_count", 64'(fifo_count), 64'd0);
      chk("rst_sent", 64'(sent_cnt), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_err", 64'(err_pulse), 64'd0);
      chk("rst_rdy", 64'(cmd_ready), 64'd1);

      // First packet, router ready
      cmd(8'd3, 8'd0, 32'hDEADBEEF); out_ready = 1'b1;
      tick(); cmd_valid = 1'b0;
      chk("p1_valid", 64'(out_valid), 64'd1);
      chk("p1_pkt", out_pkt, 64'h20220102_DEADBEEF);
      tick();
      chk("p1_sent", 64'(sent_cnt), 64'd1);
      chk("p1_empty", 64'(out_valid), 64'd0);

      cmd(8'd0, 8'd3, 32'h00000005);
      tick(); cmd_valid = 1'b0;
      chk("p2_pkt", out_pkt, 64'hC0110102_00000005);
      tick();
      chk("p2_sent", 64'(sent_cnt), 64'd2);

      // Fill with router stalled: five commands, only four fit
      out_ready = 1'b0; accepts = 0;
      for (int i = 0; i < 5; i++) begin
         cmd(8'd2, 8'd3, 32'h100 + 32'(i));
         if (cmd_ready) accepts++;
         tick();
      end
      chk("fill_accepts", 64'(accepts), 64'd4);
      chk("fill_count", 64'(fifo_count), 64'd4);
      chk("fill_rdy", 64'(cmd_ready), 64'd0);
      chk("fill_head_stable", out_pkt, 64'h00110102_00000100);
      cmd_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("drain_rdy_back", 64'(cmd_ready), 64'd1);
      chk("drain_head1", out_pkt, 64'h80110102_00000101);
      tick();
      chk("drain_head2", out_pkt, 64'h00110102_00000102);
      tick();
      chk("drain_head3", out_pkt, 64'h80110102_00000103);
      tick();
      chk("drain_empty", 64'(fifo_count), 64'd0);
      chk("drain_sent", 64'(sent_cnt), 64'd6);

      // Out-of-range destination
      out_ready = 1'b0;
      cmd(8'd4, 8'd0, 32'h0BAD0BAD);
      tick(); cmd_valid = 1'b0;
      chk("bad_err", 64'(err_pulse), 64'd1);
      chk("bad_drop", 64'(drop_cnt), 64'd1);
      chk("bad_count", 64'(fifo_count), 64'd0);
      tick();
      chk("bad_err_clear", 64'(err_pulse), 64'd0);
      cmd(8'd3, 8'd0, 32'h000000A5);
      tick(); cmd_valid = 1'b0;
      chk("after_bad_vc0", out_pkt, 64'h20220102_000000A5);

      // Simultaneous push and pop at occupancy 1
      cmd(8'd0, 8'd3, 32'h00000077); out_ready = 1'b1;
      tick(); cmd_valid = 1'b0; out_ready = 1'b0;
      chk("pp_count", 64'(fifo_count), 64'd1);
      chk("pp_head", out_pkt, 64'hC0110102_00000077);
      chk("pp_sent", 64'(sent_cnt), 64'd7);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      chk("pp_drained", 64'(fifo_count), 64'd0);

      // Three packets queued (vc toggle ends at 1), then reset
      for (int i = 0; i < 3; i++) begin
         cmd(8'd3, 8'd0, 32'(i));
         tick();
      end
      cmd_valid = 1'b0;
      chk("pre_rst_count", 64'(fifo_count), 64'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_count", 64'(fifo_count), 64'd0);
      chk("mid_rst_pkt", out_pkt, 64'd0);
      chk("mid_rst_sent", 64'(sent_cnt), 64'd0);
      chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
      cmd(8'd3, 8'd0, 32'h00000033);
      tick(); cmd_valid = 1'b0;
      chk("post_rst_vc0", out_pkt, 64'h20220102_00000033);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
